// File: rtl/pp_accumulator_if.sv
// Handshake bundle between a partial-product producer and pp_accumulator.
// The producer uses the master modport; the accumulator uses the slave modport.
interface pp_accumulator_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_pp;
  logic [5:0] in_exp;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;

  modport master (
    output in_valid, in_pp, in_exp, in_last, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_pp, in_exp, in_last, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pp_accumulator.sv
// Sums signed, exponent-shifted partial products of a group into a 72-bit register,
// then normalizes the sum into a packed {sign, exp[4:0], mant[1:0]} result.
module pp_accumulator #(
  parameter int signed EXP_OFFSET = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  pp_accumulator_if.slave   bus
);

  typedef enum logic [1:0] {
    ACC  = 2'd0,
    NORM = 2'd1,
    OUT  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [71:0]        acc_q, acc_d;
  logic               out_valid_q, out_valid_d;
  logic [7:0]         out_data_q, out_data_d;

  logic [71:0]        mag_s;
  logic [71:0]        term_s;
  logic [71:0]        abs_s;
  logic [71:0]        norm_s;
  logic [6:0]         lead_s;
  logic signed [31:0] exp_s;
  logic [7:0]         packed_s;

  // Signed term of the current beat; a cleared leading-one bit means a zero term.
  always_comb begin
    mag_s = {69'd0, bus.in_pp[2:0]} << bus.in_exp;
    if (!bus.in_pp[2]) begin
      term_s = 72'd0;
    end else if (bus.in_pp[3]) begin
      term_s = 72'd0 - mag_s;
    end else begin
      term_s = mag_s;
    end
  end

  // Normalization of acc; shifting the leading one to bit 71 yields the truncated mantissa.
  always_comb begin
    abs_s  = acc_q[71] ? (72'd0 - acc_q) : acc_q;
    lead_s = 7'd0;
    for (int i = 0; i < 72; i++) begin
      lead_s = abs_s[i] ? 7'(i) : lead_s;
    end
    norm_s = abs_s << (7'd71 - lead_s);
    exp_s  = int'(lead_s) - 32'sd2 - EXP_OFFSET;
    if (abs_s == 72'd0) begin
      packed_s = 8'h00;
    end else if (exp_s < 32'sd0) begin
      packed_s = 8'h00;
    end else if (exp_s > 32'sd31) begin
      packed_s = {acc_q[71], 5'b11111, 2'b11};
    end else begin
      packed_s = {acc_q[71], exp_s[4:0], norm_s[70:69]};
    end
  end

  // Next-state and datapath updates for the ACC/NORM/OUT sequence.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    case (state_q)
      ACC: begin
        if (bus.in_valid) begin
          acc_d   = acc_q + term_s;
          state_d = bus.in_last ? NORM : ACC;
        end else begin
          state_d = ACC;
        end
      end
      NORM: begin
        out_data_d  = packed_s;
        out_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          acc_d       = 72'd0;
          state_d     = ACC;
        end else begin
          state_d = OUT;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        acc_d       = 72'd0;
        state_d     = ACC;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial sum or pending result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACC;
      acc_q       <= 72'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign bus.in_ready  = (state_q == ACC);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_pp_accumulator.sv
// Drives two accumulators (EXP_OFFSET 0 and 1) in lockstep and compares both
// against a reference computed from the group's terms with plain arithmetic.
module tb_pp_accumulator;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pp_accumulator_if ia();
  pp_accumulator_if ib();

  assign ib.in_valid  = ia.in_valid;
  assign ib.in_pp     = ia.in_pp;
  assign ib.in_exp    = ia.in_exp;
  assign ib.in_last   = ia.in_last;
  assign ib.out_ready = ia.out_ready;

  pp_accumulator #(.EXP_OFFSET(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(ia));
  pp_accumulator #(.EXP_OFFSET(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(ib));

  int n_checks = 0;
  int n_errors = 0;

  logic [3:0] g_pp[$];
  logic [5:0] g_ex[$];

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Value of one term in units of 2^-2, as a 72-bit two's-complement number.
  function automatic logic [71:0] term_val(input logic [3:0] pp, input logic [5:0] ex);
    logic [71:0] mag;
    if (!pp[2]) return 72'd0;
    mag = 72'(pp[2:0]) * (72'd1 << ex);
    return pp[3] ? (72'd0 - mag) : mag;
  endfunction

  function automatic logic [7:0] ref_pack(input logic [71:0] sum, input int off);
    logic [71:0] m;
    logic [71:0] tmp;
    logic [1:0]  mant;
    logic        s;
    int          p;
    int          e;
    s = sum[71];
    m = s ? (72'd0 - sum) : sum;
    if (m == 72'd0) return 8'h00;
    tmp = m;
    p   = -1;
    while (tmp != 72'd0) begin
      tmp = tmp >> 1;
      p++;
    end
    if (p >= 2) mant = 2'((m >> (p - 2)) & 72'd3);
    else        mant = 2'((m << (2 - p)) & 72'd3);
    e = p - 2 - off;
    if (e < 0)  return 8'h00;
    if (e > 31) return {s, 7'h7F};
    return {s, 5'(e), mant};
  endfunction

  task automatic drive_beat(input logic [3:0] pp, input logic [5:0] ex, input logic last);
    if ($urandom_range(0, 3) == 0) begin
      ia.in_valid = 1'b0;
      ia.in_pp    = 4'($urandom);
      @(posedge clk); #1;
    end
    ia.in_valid = 1'b1;
    ia.in_pp    = pp;
    ia.in_exp   = ex;
    ia.in_last  = last;
    @(posedge clk); #1;
  endtask

  // Sends g_pp/g_ex as one group, then checks latency, both results, hold and release.
  task automatic run_group(input string tag, input int hold, input int lit0, input int lit1);
    logic [71:0] sum;
    logic [7:0]  e0;
    logic [7:0]  e1;
    sum = 72'd0;
    foreach (g_pp[i]) sum = sum + term_val(g_pp[i], g_ex[i]);
    e0 = ref_pack(sum, 0);
    e1 = ref_pack(sum, 1);
    foreach (g_pp[i]) drive_beat(g_pp[i], g_ex[i], (i == g_pp.size() - 1));
    ia.in_valid = 1'b1;
    ia.in_pp    = 4'b0111;
    ia.in_exp   = 6'd20;
    ia.in_last  = 1'b1;
    check({tag, " norm in_ready"}, 72'(ia.in_ready), 72'd0);
    check({tag, " norm out_valid"}, 72'(ia.out_valid), 72'd0);
    @(posedge clk); #1;
    check({tag, " out_valid"}, 72'(ia.out_valid), 72'd1);
    check({tag, " data off0"}, 72'(ia.out_data), 72'(e0));
    check({tag, " data off1"}, 72'(ib.out_data), 72'(e1));
    if (lit0 >= 0) check({tag, " data lit0"}, 72'(ia.out_data), 72'(lit0));
    if (lit1 >= 0) check({tag, " data lit1"}, 72'(ib.out_data), 72'(lit1));
    for (int k = 0; k < hold; k++) begin
      ia.out_ready = 1'b0;
      @(posedge clk); #1;
      check({tag, " hold data"}, 72'(ia.out_data), 72'(e0));
      check({tag, " hold valid"}, 72'(ia.out_valid), 72'd1);
      check({tag, " hold in_ready"}, 72'(ia.in_ready), 72'd0);
    end
    ia.out_ready = 1'b1;
    check({tag, " hs in_ready"}, 72'(ia.in_ready), 72'd0);
    @(posedge clk); #1;
    ia.in_valid  = 1'b0;
    ia.in_last   = 1'b0;
    ia.out_ready = 1'b0;
    check({tag, " done valid"}, 72'(ia.out_valid), 72'd0);
    check({tag, " done in_ready"}, 72'(ia.in_ready), 72'd1);
    check({tag, " done data"}, 72'(ia.out_data), 72'(e0));
  endtask

  task automatic set_group1(input logic [3:0] pp, input logic [5:0] ex);
    g_pp.delete(); g_ex.delete();
    g_pp.push_back(pp); g_ex.push_back(ex);
  endtask

  task automatic set_group2(input logic [3:0] pa, input logic [5:0] xa,
                            input logic [3:0] pb, input logic [5:0] xb);
    set_group1(pa, xa);
    g_pp.push_back(pb); g_ex.push_back(xb);
  endtask

  initial begin
    rst_n        = 1'b0;
    ia.in_valid  = 1'b0;
    ia.in_pp     = 4'd0;
    ia.in_exp    = 6'd0;
    ia.in_last   = 1'b0;
    ia.out_ready = 1'b0;
    #12;
    check("rst in_ready", 72'(ia.in_ready), 72'd1);
    check("rst out_valid", 72'(ia.out_valid), 72'd0);
    check("rst out_data", 72'(ia.out_data), 72'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    set_group1(4'b0110, 6'd5);                    run_group("single", 0, 8'h16, -1);
    set_group2(4'b0100, 6'd3, 4'b0100, 6'd3);     run_group("pair", 1, 8'h10, -1);
    set_group2(4'b0101, 6'd2, 4'b1101, 6'd2);     run_group("cancel", 0, 8'h00, 8'h00);
    set_group2(4'b1111, 6'd1, 4'b0100, 6'd0);     run_group("neg", 0, 8'h85, -1);
    set_group1(4'b0100, 6'd40);                   run_group("sat", 0, 8'h7F, 8'h7F);
    set_group1(4'b0111, 6'd0);                    run_group("uflow", 0, 8'h03, 8'h00);
    set_group1(4'b1000, 6'd63);                   run_group("zero", 0, 8'h00, 8'h00);
    set_group1(4'b0110, 6'd5);                    run_group("stall5", 5, 8'h16, -1);

    // Reset mid-group: three of five beats, then a fresh two-beat group.
    drive_beat(4'b0111, 6'd9, 1'b0);
    drive_beat(4'b0110, 6'd4, 1'b0);
    drive_beat(4'b1101, 6'd2, 1'b0);
    ia.in_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    check("midrst out_valid", 72'(ia.out_valid), 72'd0);
    check("midrst in_ready", 72'(ia.in_ready), 72'd1);
    check("midrst out_data", 72'(ia.out_data), 72'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    set_group2(4'b0100, 6'd3, 4'b0100, 6'd3);     run_group("postrst", 0, 8'h10, -1);

    for (int g = 0; g < 40; g++) begin
      int n;
      n = $urandom_range(1, 6);
      g_pp.delete(); g_ex.delete();
      for (int i = 0; i < n; i++) begin
        g_pp.push_back(4'($urandom));
        g_ex.push_back(($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63))
                                                   : 6'($urandom_range(0, 12)));
      end
      run_group("rand", $urandom_range(0, 2), -1, -1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
